branch_checkpoint_ctrl: RTL and testbench
=========================================

# branch_checkpoint_ctrl

Multi-entry branch checkpoint controller between rename and the branch-resolution/ROB recovery path. It replaces rename's single-checkpoint stall with `NUM_CKPT` in-order checkpoint slots. Each slot snapshots the map table, free-list pointer and ROB tag when a branch renames. On correct resolution it retires slots in order. On mispredict it sequences a timed recovery: a one-cycle restore pulse, a squash mask for the mispredicted and all younger checkpoints, and a rename stall window.

## Interface
Parameters:
- `NUM_CKPT`, 4: checkpoint slots; power of two, ≥2. `CKPT_BITS` = log2(`NUM_CKPT`).
- `NUM_ARCH_REGS`, 32: architectural registers.
- `PHYS_REG_BITS`, 7: physical register index width.
- `ROB_BITS`, 5: ROB tag width.
- `RECOVER_CYCLES`, 2: cycles `stall` stays high per recovery, counted from the restore cycle; ≥1.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `alloc_req`  in  1  rename has a branch to checkpoint this cycle
- `ckpt_map_in`  in  `NUM_ARCH_REGS`×`PHYS_REG_BITS`  map table snapshot
- `ckpt_freelist_ptr_in`  in  `PHYS_REG_BITS`  free-list pointer snapshot
- `ckpt_rob_tag_in`  in  `ROB_BITS`  ROB tag snapshot
- `alloc_gnt`  out  1  combinational; the checkpoint is taken at this clock edge
- `alloc_id`  out  `CKPT_BITS`  combinational; slot ID granted (current tail)
- `resolve_valid`  in  1  branch resolution event
- `resolve_id`  in  `CKPT_BITS`  checkpoint ID of the resolving branch
- `resolve_mispredict`  in  1  1 = mispredicted, 0 = correct
- `flush`  in  1  full pipeline flush; discards all checkpoints
- `restore_valid`  out  1  registered one-cycle restore pulse
- `restore_map_table`  out  `NUM_ARCH_REGS`×`PHYS_REG_BITS`  registered restore data
- `restore_freelist_ptr`  out  `PHYS_REG_BITS`  registered restore data
- `restore_rob_tag`  out  `ROB_BITS`  registered restore data
- `squash_mask`  out  `NUM_CKPT`  registered; valid with `restore_valid`; bit i = slot i squashed
- `stall`  out  1  rename must not proceed
- `free_count`  out  `CKPT_BITS`+1  free slots

## Operation
- Storage is a circular buffer of slots. Each slot holds `valid`, `done` and snapshot data. Pointers are `head` (oldest) and `tail` (next allocation), plus `count` for occupancy.
- **Allocation:**
  - `alloc_gnt = alloc_req && state==IDLE && count<NUM_CKPT && !(resolve_valid && resolve_mispredict && slot[resolve_id].valid) && !flush`.
  - `alloc_id = tail`.
  - On grant: write the snapshot to slot `tail`, set `valid`=1 and `done`=0, increment `tail` modulo `NUM_CKPT`, increment `count`.
- **Correct resolve** (`resolve_valid && !resolve_mispredict`): if `slot[resolve_id].valid`, set its `done` bit. If the slot is invalid, ignore the event.
- **Retire:** each cycle, if `slot[head].valid && slot[head].done`, clear the slot, increment `head`, decrement `count`. At most one slot retires per cycle. A `done` bit set in cycle t can retire no earlier than t+1.
- **Mispredict** (`resolve_valid && resolve_mispredict && slot[resolve_id].valid`), with `id = resolve_id`:
  - Register slot `id` data onto the `restore_*` outputs.
  - Set `squash_mask` bits for `id` through `tail-1`, inclusive, with wrap-around.
  - Invalidate those slots.
  - Set `tail` to `id` and `count` to `(id - head) mod NUM_CKPT`.
  - Enter RESTORE.
  - A mispredict on an invalid slot is ignored.
- **FSM:**
  - IDLE → RESTORE on an accepted mispredict.
  - RESTORE lasts one cycle with `restore_valid`=1. It then goes to WAIT if `RECOVER_CYCLES>1`, else to IDLE.
  - WAIT counts `RECOVER_CYCLES-1` cycles, then goes to IDLE.
  - An accepted mispredict in RESTORE or WAIT re-enters RESTORE with the new slot and restarts the count. The slot is necessarily older, because younger slots are already invalid.
- `stall = (state != IDLE) || (count == NUM_CKPT)`.
- **Flush:** highest priority below `rst`. Clear all `valid`/`done` bits, set `head`=`tail`=`count`=0, go to IDLE. No restore pulse is produced. `restore_valid`=0 and `squash_mask`=0 in the next cycle.
- **Priority:** `rst` > `flush` > mispredict > correct resolve / retire / alloc. The last three are concurrent and independent.

## Timing
- **Reset values:** `restore_valid` 0, `squash_mask` 0, `restore_*` data 0, `stall` 0, `free_count` `NUM_CKPT`, FSM IDLE, all slots invalid, pointers 0. `alloc_gnt` follows its equation and is 0 after reset only if `alloc_req`=0.
- `alloc_gnt` and `alloc_id` are combinational in the same cycle. The slot becomes valid at the following edge.
- **Mispredict latency:** accepted in cycle t; `restore_valid`, `restore_*` and `squash_mask` are valid in cycle t+1 only.
- `stall` is high from t+1 through t+`RECOVER_CYCLES`, inclusive, plus whenever the buffer is full.
- `free_count` is registered and equals `NUM_CKPT - count` after each edge.
- `rst` mid-recovery returns everything to reset values at the next edge.

## Test plan
- **Fill/full:** 4 back-to-back `alloc_req` → `alloc_id` 0,1,2,3; a 5th request gets `alloc_gnt`=0, `stall`=1, `free_count`=0.
- **Out-of-order resolve:** with slots 0–3 allocated, resolve correct 2, then 0, then 1 → `head` retires 0, 1, 2 on consecutive cycles after slot 1 resolves; `free_count` reaches 3.
- **Mispredict with wrap:**
  - Setup: `head`=2 and valid slots 2,3,0,1 (wrapped).
  - Stimulus: mispredict id 3.
  - Response at t+1: `restore_valid`=1 with slot 3 data, `squash_mask`=4'b1011, `stall`=1 for 2 cycles, `free_count`=3.
- **Simultaneous alloc + mispredict:** same cycle → `alloc_gnt`=0 and the mispredict restores correctly. A mispredict on an invalid ID with `alloc_req` → ignored and allocation granted.
- **Nested mispredict:** mispredict id 2, then id 1 during WAIT → a second restore pulse with slot 1 data, `squash_mask` bit 1 only, `stall` extended 2 cycles from the new pulse.
- **Flush/reset mid-recovery:** `flush` during RESTORE → next cycle all slots free, `stall`=0, `restore_valid`=0. `rst` → all outputs at reset values.

Source files
------------

// File: rtl/branch_checkpoint_ctrl.sv
// Multi-slot in-order branch checkpoint store between rename and branch recovery.
// Allocation grant is combinational (same cycle); restore pulse/squash mask one cycle after an accepted mispredict.
// Rename is stalled while the store is full or while a recovery window is open.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alloc_req / alloc_gnt / id    rename branch checkpoint request, grant and granted slot (tail)
//   ckpt_*_in                     snapshot written into the granted slot
//   resolve_valid/id/mispredict   branch resolution event
//   flush                         discard every checkpoint, no restore pulse
//   restore_*                     registered one-cycle restore pulse, data and squash mask
//   stall, free_count             rename hold and number of free slots
module branch_checkpoint_ctrl #(
    parameter int  NUM_CKPT       = 4,
    parameter int  NUM_ARCH_REGS  = 32,
    parameter int  PHYS_REG_BITS  = 7,
    parameter int  ROB_BITS       = 5,
    parameter int  RECOVER_CYCLES = 2,
    localparam int CKPT_BITS      = $clog2(NUM_CKPT),
    localparam int MAP_BITS       = NUM_ARCH_REGS * PHYS_REG_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    input  logic [MAP_BITS-1:0]      ckpt_map_in,
    input  logic [PHYS_REG_BITS-1:0] ckpt_freelist_ptr_in,
    input  logic [ROB_BITS-1:0]      ckpt_rob_tag_in,
    output logic                     alloc_gnt,
    output logic [CKPT_BITS-1:0]     alloc_id,
    input  logic                     resolve_valid,
    input  logic [CKPT_BITS-1:0]     resolve_id,
    input  logic                     resolve_mispredict,
    input  logic                     flush,
    output logic                     restore_valid,
    output logic [MAP_BITS-1:0]      restore_map_table,
    output logic [PHYS_REG_BITS-1:0] restore_freelist_ptr,
    output logic [ROB_BITS-1:0]      restore_rob_tag,
    output logic [NUM_CKPT-1:0]      squash_mask,
    output logic                     stall,
    output logic [CKPT_BITS:0]       free_count
);

    localparam int WAIT_BITS = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [CKPT_BITS:0] FULL = (CKPT_BITS+1)'(NUM_CKPT);

    typedef enum logic [1:0] {IDLE, RESTORE, WAIT} state_t;

    state_t                     state;
    logic [WAIT_BITS-1:0]       wait_cnt;
    logic [NUM_CKPT-1:0]        slot_valid;
    logic [NUM_CKPT-1:0]        slot_done;
    logic [MAP_BITS-1:0]        slot_map [NUM_CKPT];
    logic [PHYS_REG_BITS-1:0]   slot_fl  [NUM_CKPT];
    logic [ROB_BITS-1:0]        slot_rob [NUM_CKPT];
    logic [CKPT_BITS-1:0]       head;
    logic [CKPT_BITS-1:0]       tail;
    logic [CKPT_BITS:0]         count;

    logic                       mispredict;
    logic                       resolve_ok;
    logic                       retire;
    logic [CKPT_BITS-1:0]       mp_age;
    logic [NUM_CKPT-1:0]        squash_next;

    assign mispredict = resolve_valid && resolve_mispredict && slot_valid[resolve_id];
    assign resolve_ok = resolve_valid && !resolve_mispredict && slot_valid[resolve_id];
    // done is read from the register, so a slot resolved this cycle retires next cycle at the earliest
    assign retire     = slot_valid[head] && slot_done[head];
    assign alloc_gnt  = alloc_req && (state == IDLE) && (count < FULL) && !mispredict && !flush;
    assign alloc_id   = tail;
    assign stall      = (state != IDLE) || (count == FULL);
    assign free_count = FULL - count;

    // Age relative to head: the mispredicted slot and everything younger that is still live is squashed.
    assign mp_age = resolve_id - head;

    always_comb begin
        logic [CKPT_BITS-1:0] age;
        age         = '0;
        squash_next = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            age            = CKPT_BITS'(i) - head;
            squash_next[i] = slot_valid[i] && (age >= mp_age);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            wait_cnt             <= '0;
            slot_valid           <= '0;
            slot_done            <= '0;
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            restore_valid        <= 1'b0;
            restore_map_table    <= '0;
            restore_freelist_ptr <= '0;
            restore_rob_tag      <= '0;
            squash_mask          <= '0;
        end else if (flush) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            slot_valid    <= '0;
            slot_done     <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            restore_valid <= 1'b0;
            squash_mask   <= '0;
        end else if (mispredict) begin
            // Retire and allocation are held off for this cycle; head is unchanged so the
            // surviving occupancy is simply the distance from head to the mispredicted slot.
            restore_valid        <= 1'b1;
            restore_map_table    <= slot_map[resolve_id];
            restore_freelist_ptr <= slot_fl[resolve_id];
            restore_rob_tag      <= slot_rob[resolve_id];
            squash_mask          <= squash_next;
            slot_valid           <= slot_valid & ~squash_next;
            slot_done            <= slot_done & ~squash_next;
            tail                 <= resolve_id;
            count                <= {1'b0, mp_age};
            state                <= RESTORE;
            wait_cnt             <= '0;
        end else begin
            restore_valid <= 1'b0;
            squash_mask   <= '0;

            if (resolve_ok) begin
                slot_done[resolve_id] <= 1'b1;
            end
            if (retire) begin
                slot_valid[head] <= 1'b0;
                slot_done[head]  <= 1'b0;
                head             <= head + 1'b1;
            end
            if (alloc_gnt) begin
                slot_valid[tail] <= 1'b1;
                slot_done[tail]  <= 1'b0;
                slot_map[tail]   <= ckpt_map_in;
                slot_fl[tail]    <= ckpt_freelist_ptr_in;
                slot_rob[tail]   <= ckpt_rob_tag_in;
                tail             <= tail + 1'b1;
            end
            count <= count + (CKPT_BITS+1)'(alloc_gnt) - (CKPT_BITS+1)'(retire);

            // RESTORE is the first stall cycle; WAIT covers the remaining RECOVER_CYCLES-1.
            case (state)
                RESTORE: begin
                    if (RECOVER_CYCLES > 1) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_BITS'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_BITS'(RECOVER_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
// Bench for branch_checkpoint_ctrl: directed scenarios plus random traffic,
// checked against an ordered-list model of live checkpoints and a recovery timer.
module tb_branch_checkpoint_ctrl;

    localparam int N     = 4;
    localparam int CB    = 2;
    localparam int R     = 2;
    localparam int MAP_W = 32 * 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_req;
    logic [MAP_W-1:0] ckpt_map_in;
    logic [6:0]       ckpt_freelist_ptr_in;
    logic [4:0]       ckpt_rob_tag_in;
    logic             alloc_gnt;
    logic [CB-1:0]    alloc_id;
    logic             resolve_valid;
    logic [CB-1:0]    resolve_id;
    logic             resolve_mispredict;
    logic             flush;
    logic             restore_valid;
    logic [MAP_W-1:0] restore_map_table;
    logic [6:0]       restore_freelist_ptr;
    logic [4:0]       restore_rob_tag;
    logic [N-1:0]     squash_mask;
    logic             stall;
    logic [CB:0]      free_count;

    branch_checkpoint_ctrl #(
        .NUM_CKPT(N), .NUM_ARCH_REGS(32), .PHYS_REG_BITS(7), .ROB_BITS(5), .RECOVER_CYCLES(R)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .ckpt_map_in(ckpt_map_in),
        .ckpt_freelist_ptr_in(ckpt_freelist_ptr_in), .ckpt_rob_tag_in(ckpt_rob_tag_in),
        .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
        .resolve_valid(resolve_valid), .resolve_id(resolve_id),
        .resolve_mispredict(resolve_mispredict), .flush(flush),
        .restore_valid(restore_valid), .restore_map_table(restore_map_table),
        .restore_freelist_ptr(restore_freelist_ptr), .restore_rob_tag(restore_rob_tag),
        .squash_mask(squash_mask), .stall(stall), .free_count(free_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               id;
        logic [MAP_W-1:0] map;
        logic [6:0]       fl;
        logic [4:0]       rob;
        bit               done;
    } entry_t;

    typedef struct {
        bit gnt;
        int id;
        bit stall;
        int free;
    } cyc_rec_t;

    typedef struct {
        logic [MAP_W-1:0] map;
        logic [6:0]       fl;
        logic [4:0]       rob;
        logic [N-1:0]     mask;
        int               cyc;
    } rst_rec_t;

    // Model: live checkpoints oldest-first, head slot id, remaining stall cycles of recovery.
    entry_t   ck[$];
    int       m_head;
    int       rec_left;

    cyc_rec_t cyc_q[$];
    rst_rec_t rq[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every presented cycle response and every restore pulse.
    cyc_rec_t mr;
    rst_rec_t mrr;
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mr = cyc_q.pop_front();
            check("alloc_gnt", 256'(alloc_gnt), 256'(mr.gnt));
            check("alloc_id", 256'(alloc_id), 256'(mr.id));
            check("stall", 256'(stall), 256'(mr.stall));
            check("free_count", 256'(free_count), 256'(mr.free));
        end
        if (restore_valid === 1'b1) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_restore at cycle %0d: got restore_valid 1 expected 0", cyc);
            end else begin
                mrr = rq.pop_front();
                check("restore_cycle", 256'(cyc), 256'(mrr.cyc));
                check("restore_map", 256'(restore_map_table), 256'(mrr.map));
                check("restore_fl", 256'(restore_freelist_ptr), 256'(mrr.fl));
                check("restore_rob", 256'(restore_rob_tag), 256'(mrr.rob));
                check("squash_mask", 256'(squash_mask), 256'(mrr.mask));
            end
        end
    end

    task automatic model_clear();
        ck.delete();
        m_head   = 0;
        rec_left = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0; flush = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        rst = 1'b0;
        check("rst_restore_valid", 256'(restore_valid), 256'(0));
        check("rst_squash_mask", 256'(squash_mask), 256'(0));
        check("rst_restore_map", 256'(restore_map_table), 256'(0));
        check("rst_restore_fl_rob", 256'({restore_freelist_ptr, restore_rob_tag}), 256'(0));
    endtask

    task automatic step(input bit areq, input bit rv, input bit rm, input int rid, input bit fl);
        cyc_rec_t r;
        rst_rec_t rr;
        entry_t   e;
        int       pos;
        int       c_now;
        bit       mp;
        bit       ret;

        alloc_req          = areq;
        resolve_valid      = rv;
        resolve_mispredict = rm;
        resolve_id         = CB'(rid);
        flush              = fl;
        for (int k = 0; k < MAP_W / 32; k++) ckpt_map_in[k*32 +: 32] = $urandom();
        ckpt_freelist_ptr_in = 7'($urandom());
        ckpt_rob_tag_in      = 5'($urandom());

        pos = -1;
        for (int k = 0; k < ck.size(); k++) if (ck[k].id == rid) pos = k;
        mp = rv && rm && (pos >= 0);

        r.gnt   = areq && (rec_left == 0) && (ck.size() < N) && !mp && !fl;
        r.id    = (m_head + ck.size()) % N;
        r.stall = (rec_left > 0) || (ck.size() == N);
        r.free  = N - ck.size();
        cyc_q.push_back(r);

        e.id = r.id; e.map = ckpt_map_in; e.fl = ckpt_freelist_ptr_in; e.rob = ckpt_rob_tag_in; e.done = 1'b0;
        c_now = cyc;

        @(posedge clk);
        if (fl) begin
            model_clear();
        end else if (mp) begin
            rr.map  = ck[pos].map;
            rr.fl   = ck[pos].fl;
            rr.rob  = ck[pos].rob;
            rr.mask = '0;
            for (int k = pos; k < ck.size(); k++) rr.mask[ck[k].id] = 1'b1;
            rr.cyc  = c_now + 1;
            rq.push_back(rr);
            while (ck.size() > pos) void'(ck.pop_back());
            rec_left = R;
        end else begin
            ret = (ck.size() > 0) && ck[0].done;
            if (rv && !rm && pos >= 0) begin
                entry_t t;
                t = ck[pos];
                t.done = 1'b1;
                ck[pos] = t;
            end
            if (ret) begin
                void'(ck.pop_front());
                m_head = (m_head + 1) % N;
            end
            if (r.gnt) ck.push_back(e);
            if (rec_left > 0) rec_left--;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0; flush = 1'b0;
        resolve_id = '0; ckpt_map_in = '0; ckpt_freelist_ptr_in = '0; ckpt_rob_tag_in = '0;
        @(posedge clk);
        do_reset();
        idle(1);

        // Fill to full; fifth request refused while stalled
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
        // Out-of-order correct resolves 2, 0, 1, then in-order retirement
        step(0, 1, 0, 2, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        idle(4);

        // Wrapped buffer: head 2, live slots 2,3,0,1; mispredict slot 3
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        idle(3);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 3, 0);
        idle(4);

        // Alloc with same-cycle mispredict, then mispredict on an invalid id with alloc
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        idle(3);
        step(1, 1, 1, 3, 0);
        idle(2);

        // Nested mispredict during WAIT
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0);
        step(0, 1, 1, 2, 0);
        idle(1);
        step(0, 1, 1, 1, 0);
        idle(4);

        // Flush while in RESTORE
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        idle(2);

        // Reset while in RESTORE
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        do_reset();
        idle(2);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)),
                     $urandom_range(0, 2) != 0,
                     $urandom_range(0, 4) == 0,
                     int'($urandom_range(0, N - 1)),
                     $urandom_range(0, 63) == 0);
            end
        end
        idle(4);
        @(negedge clk);
        check("pending_restores", 256'(rq.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
